ddr_debug_monitor: RTL

- Parametrised debug/performance monitor for the DDR path.
- Tracks read and write transactions on NUM_PORTS core-side memory ports:
  - counts completions
  - measures per-transaction latency (last and max)
  - flags protocol anomalies
- Also counts MIG app-interface stalls and read beats.
- Statistics for one selected port are presented through a registered readout for the debug/UART dump path.

---
 rtl/ddr_debug_monitor_pkg.sv | 24 ++
 rtl/ddr_debug_monitor_txn_tracker.sv | 93 +++++++++
 rtl/ddr_debug_monitor.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/ddr_debug_monitor_pkg.sv
// Shared types for the DDR debug monitor: tracker states, flag width and
// the fixed-width per-port record used by debug-dump consumers.
package ddr_debug_monitor_pkg;

   localparam int MON_ERR_W = 4;
   localparam int MON_CNT_W = 64;
   localparam int MON_LAT_W = 16;

   typedef enum logic {
      TRK_IDLE = 1'b0,
      TRK_BUSY = 1'b1
   } trk_state_e;

   typedef struct packed {
      logic [MON_CNT_W-1:0] rd_cnt;
      logic [MON_CNT_W-1:0] wr_cnt;
      logic [MON_LAT_W-1:0] rd_lat_last;
      logic [MON_LAT_W-1:0] rd_lat_max;
      logic [MON_LAT_W-1:0] wr_lat_last;
      logic [MON_LAT_W-1:0] wr_lat_max;
      logic [MON_ERR_W-1:0] err_flags;
   } DDRMonPortPack;

endpackage

// File: rtl/ddr_debug_monitor_txn_tracker.sv
// One-direction transaction tracker: request/completion FSM with a latency
// accumulator, saturating completion count, last/max latency and sticky flags.
module ddr_txn_tracker
   import ddr_debug_monitor_pkg::*;
#(
   parameter int CNT_W = 64,
   parameter int LAT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req,
   input  logic             vld,
   input  logic             clear,
   input  logic             freeze,
   output logic             done,
   output logic [CNT_W-1:0] cnt,
   output logic [LAT_W-1:0] lat_last,
   output logic [LAT_W-1:0] lat_max,
   output logic             spur,
   output logic             rereq
);

   trk_state_e       state;
   logic [LAT_W-1:0] lat_reg;
   logic [LAT_W-1:0] done_lat;
   logic             spur_evt;
   logic             rereq_evt;

   // A completion in BUSY counts the completion edge itself, hence lat+1.
   always_comb begin
      done      = 1'b0;
      done_lat  = '0;
      spur_evt  = 1'b0;
      rereq_evt = 1'b0;
      if (state == TRK_IDLE) begin
         done     = req & vld;
         spur_evt = ~req & vld;
      end else begin
         done      = vld;
         rereq_evt = req & ~vld;
         done_lat  = (lat_reg == '1) ? lat_reg : lat_reg + LAT_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= TRK_IDLE;
         lat_reg  <= '0;
         cnt      <= '0;
         lat_last <= '0;
         lat_max  <= '0;
         spur     <= 1'b0;
         rereq    <= 1'b0;
      end else begin
         case (state)
            TRK_IDLE: begin
               if (req && !vld) begin
                  state   <= TRK_BUSY;
                  lat_reg <= '0;
               end
            end
            TRK_BUSY: begin
               if (vld)
                  state <= TRK_IDLE;
               else if (lat_reg != '1)
                  lat_reg <= lat_reg + LAT_W'(1);
            end
            default: state <= TRK_IDLE;
         endcase

         // Statistics obey clear/freeze; the FSM above never does.
         if (clear) begin
            cnt      <= '0;
            lat_last <= '0;
            lat_max  <= '0;
            spur     <= 1'b0;
            rereq    <= 1'b0;
         end else if (!freeze) begin
            if (done) begin
               cnt      <= (cnt == '1) ? cnt : cnt + CNT_W'(1);
               lat_last <= done_lat;
               if (done_lat > lat_max)
                  lat_max <= done_lat;
            end
            if (spur_evt)
               spur <= 1'b1;
            if (rereq_evt)
               rereq <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/ddr_debug_monitor.sv
// DDR path debug monitor: per-port read/write trackers, MIG app-interface
// stall/beat counters and a registered per-port readout for the dump path.
module ddr_debug_monitor
   import ddr_debug_monitor_pkg::*;
#(
   parameter int NUM_PORTS = 2,
   parameter int CNT_W     = 64,
   parameter int LAT_W     = 16,
   parameter int SEL_W     = 3
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NUM_PORTS-1:0] ren_mem,
   input  logic [NUM_PORTS-1:0] rvalid_mem,
   input  logic [NUM_PORTS-1:0] wen_mem,
   input  logic [NUM_PORTS-1:0] wvalid_mem,
   input  logic                 app_en,
   input  logic                 app_rdy,
   input  logic                 app_wdf_wren,
   input  logic                 app_wdf_rdy,
   input  logic                 app_rd_data_valid,
   input  logic                 mon_clear,
   input  logic                 mon_freeze,
   input  logic [SEL_W-1:0]     mon_sel,
   output logic [CNT_W-1:0]     rd_cnt,
   output logic [CNT_W-1:0]     wr_cnt,
   output logic [LAT_W-1:0]     rd_lat_last,
   output logic [LAT_W-1:0]     rd_lat_max,
   output logic [LAT_W-1:0]     wr_lat_last,
   output logic [LAT_W-1:0]     wr_lat_max,
   output logic [MON_ERR_W-1:0] err_flags,
   output logic [CNT_W-1:0]     cmd_stall_cnt,
   output logic [CNT_W-1:0]     wdf_stall_cnt,
   output logic [CNT_W-1:0]     rd_beat_cnt,
   output logic [CNT_W-1:0]     visit_times
);

   localparam int K_W = $clog2(2 * NUM_PORTS + 1);

   logic [NUM_PORTS-1:0] rd_done, wr_done;
   logic [NUM_PORTS-1:0] rd_spur, wr_spur, rd_rereq, wr_rereq;
   logic [CNT_W-1:0]     rd_cnt_p      [NUM_PORTS];
   logic [CNT_W-1:0]     wr_cnt_p      [NUM_PORTS];
   logic [LAT_W-1:0]     rd_lat_last_p [NUM_PORTS];
   logic [LAT_W-1:0]     rd_lat_max_p  [NUM_PORTS];
   logic [LAT_W-1:0]     wr_lat_last_p [NUM_PORTS];
   logic [LAT_W-1:0]     wr_lat_max_p  [NUM_PORTS];

   generate
      for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_port
         ddr_txn_tracker #(.CNT_W(CNT_W), .LAT_W(LAT_W)) u_rd (
            .clk      (clk),
            .rst      (rst),
            .req      (ren_mem[gi]),
            .vld      (rvalid_mem[gi]),
            .clear    (mon_clear),
            .freeze   (mon_freeze),
            .done     (rd_done[gi]),
            .cnt      (rd_cnt_p[gi]),
            .lat_last (rd_lat_last_p[gi]),
            .lat_max  (rd_lat_max_p[gi]),
            .spur     (rd_spur[gi]),
            .rereq    (rd_rereq[gi])
         );
         ddr_txn_tracker #(.CNT_W(CNT_W), .LAT_W(LAT_W)) u_wr (
            .clk      (clk),
            .rst      (rst),
            .req      (wen_mem[gi]),
            .vld      (wvalid_mem[gi]),
            .clear    (mon_clear),
            .freeze   (mon_freeze),
            .done     (wr_done[gi]),
            .cnt      (wr_cnt_p[gi]),
            .lat_last (wr_lat_last_p[gi]),
            .lat_max  (wr_lat_max_p[gi]),
            .spur     (wr_spur[gi]),
            .rereq    (wr_rereq[gi])
         );
      end
   endgenerate

   logic [K_W-1:0]   k_sum;
   logic [CNT_W:0]   visit_sum;
   logic [CNT_W-1:0] visit_reg, visit_next;
   logic [CNT_W-1:0] cmd_stall_reg, cmd_stall_next;
   logic [CNT_W-1:0] wdf_stall_reg, wdf_stall_next;
   logic [CNT_W-1:0] rd_beat_reg, rd_beat_next;

   // Several completions may land in one cycle, so visit_times adds k, not 1.
   always_comb begin
      k_sum = '0;
      for (int i = 0; i < NUM_PORTS; i++)
         k_sum = k_sum + K_W'(rd_done[i]) + K_W'(wr_done[i]);
      visit_sum  = {1'b0, visit_reg} + (CNT_W + 1)'(k_sum);
      visit_next = visit_sum[CNT_W] ? '1 : visit_sum[CNT_W-1:0];
      cmd_stall_next = cmd_stall_reg;
      if (app_en && !app_rdy && cmd_stall_reg != '1)
         cmd_stall_next = cmd_stall_reg + CNT_W'(1);
      wdf_stall_next = wdf_stall_reg;
      if (app_wdf_wren && !app_wdf_rdy && wdf_stall_reg != '1)
         wdf_stall_next = wdf_stall_reg + CNT_W'(1);
      rd_beat_next = rd_beat_reg;
      if (app_rd_data_valid && rd_beat_reg != '1)
         rd_beat_next = rd_beat_reg + CNT_W'(1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         visit_reg     <= '0;
         cmd_stall_reg <= '0;
         wdf_stall_reg <= '0;
         rd_beat_reg   <= '0;
      end else if (mon_clear) begin
         visit_reg     <= '0;
         cmd_stall_reg <= '0;
         wdf_stall_reg <= '0;
         rd_beat_reg   <= '0;
      end else if (!mon_freeze) begin
         visit_reg     <= visit_next;
         cmd_stall_reg <= cmd_stall_next;
         wdf_stall_reg <= wdf_stall_next;
         rd_beat_reg   <= rd_beat_next;
      end
   end

   logic [CNT_W-1:0]     sel_rd_cnt, sel_wr_cnt;
   logic [LAT_W-1:0]     sel_rd_last, sel_rd_max, sel_wr_last, sel_wr_max;
   logic [MON_ERR_W-1:0] sel_err;

   // Out-of-range selects match no port and fall through to zeros.
   always_comb begin
      sel_rd_cnt  = '0;
      sel_wr_cnt  = '0;
      sel_rd_last = '0;
      sel_rd_max  = '0;
      sel_wr_last = '0;
      sel_wr_max  = '0;
      sel_err     = '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
         if (mon_sel == SEL_W'(i)) begin
            sel_rd_cnt  = rd_cnt_p[i];
            sel_wr_cnt  = wr_cnt_p[i];
            sel_rd_last = rd_lat_last_p[i];
            sel_rd_max  = rd_lat_max_p[i];
            sel_wr_last = wr_lat_last_p[i];
            sel_wr_max  = wr_lat_max_p[i];
            sel_err     = {wr_rereq[i], rd_rereq[i], wr_spur[i], rd_spur[i]};
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_cnt        <= '0;
         wr_cnt        <= '0;
         rd_lat_last   <= '0;
         rd_lat_max    <= '0;
         wr_lat_last   <= '0;
         wr_lat_max    <= '0;
         err_flags     <= '0;
         cmd_stall_cnt <= '0;
         wdf_stall_cnt <= '0;
         rd_beat_cnt   <= '0;
         visit_times   <= '0;
      end else begin
         rd_cnt        <= sel_rd_cnt;
         wr_cnt        <= sel_wr_cnt;
         rd_lat_last   <= sel_rd_last;
         rd_lat_max    <= sel_rd_max;
         wr_lat_last   <= sel_wr_last;
         wr_lat_max    <= sel_wr_max;
         err_flags     <= sel_err;
         cmd_stall_cnt <= cmd_stall_reg;
         wdf_stall_cnt <= wdf_stall_reg;
         rd_beat_cnt   <= rd_beat_reg;
         visit_times   <= visit_reg;
      end
   end

endmodule
